// File: rtl/xbar_commutation_matrix_pkg.sv
// Shared types and helpers for the crossbar commutation matrix.
// Bus structs use the package widths, so the top-level width parameters must match them.
package xbar_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_PORTS  = 64;

  typedef struct packed {
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  cmd;
    logic [DATA_WIDTH-1:0] wdata;
  } m2s_t;

  typedef struct packed {
    logic                  ack;
    logic                  resp;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } s2m_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_WAIT_RESP,
    ST_ABORT
  } slave_state_t;

  // Multiple grants in one row resolve to the lowest index.
  function automatic int unsigned lowest_set_idx(input logic [MAX_PORTS-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbar_commutation_matrix_slave_port.sv
// One slave port: session FSM, latched owner, timeout watchdog and request mux.
// The owner is only sampled from the grant row while idle and is held for the rest of the session.
module xbar_slave_port
  import xbar_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 9,
  parameter int IDX_WIDTH      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] grant_row,
  input  m2s_t                 m_bus [N_MASTERS],
  input  logic                 s_ack,
  input  logic                 s_resp,
  output m2s_t                 s_bus,
  output logic [IDX_WIDTH-1:0] owner,
  output slave_state_t         state,
  output logic                 owner_live,
  output logic                 finished,
  output logic                 timeout,
  output logic                 busy
);

  localparam int LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LAST_INT);

  slave_state_t         state_reg, state_next;
  logic [IDX_WIDTH-1:0] owner_reg, owner_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next, cnt_inc;
  logic                 finished_reg, finished_next;
  logic                 timeout_reg, timeout_next;
  logic [IDX_WIDTH-1:0] live_idx;
  logic                 row_any;
  logic                 expired;

  assign row_any  = |grant_row;
  assign live_idx = IDX_WIDTH'(lowest_set_idx(MAX_PORTS'(grant_row)));
  assign cnt_inc  = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
  assign expired  = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    cnt_next      = cnt_reg;
    finished_next = 1'b0;
    timeout_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (row_any) begin
          state_next = ST_WAIT_ACK;
          owner_next = live_idx;
          cnt_next   = '0;
        end
      end
      ST_WAIT_ACK: begin
        cnt_next = cnt_inc;
        if (s_ack && s_resp) begin
          state_next    = ST_IDLE;
          finished_next = 1'b1;
          cnt_next      = '0;
        end else if (s_ack) begin
          state_next = ST_WAIT_RESP;
          cnt_next   = '0;
        end else if (expired) begin
          state_next = ST_ABORT;
          cnt_next   = '0;
        end
      end
      ST_WAIT_RESP: begin
        cnt_next = cnt_inc;
        // A response arriving on the expiry cycle still completes normally.
        if (s_resp) begin
          state_next    = ST_IDLE;
          finished_next = 1'b1;
          cnt_next      = '0;
        end else if (expired) begin
          state_next = ST_ABORT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        finished_next = 1'b1;
        timeout_next  = 1'b1;
        cnt_next      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= '0;
      cnt_reg      <= '0;
      finished_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      cnt_reg      <= cnt_next;
      finished_reg <= finished_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign owner      = (state_reg == ST_IDLE) ? live_idx : owner_reg;
  assign owner_live = ((state_reg == ST_IDLE) && row_any) ||
                      (state_reg == ST_WAIT_ACK) || (state_reg == ST_WAIT_RESP);
  assign s_bus      = owner_live ? m_bus[owner] : '0;
  assign state      = state_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign finished   = finished_reg;
  assign timeout    = timeout_reg;

endmodule

// File: rtl/xbar_commutation_matrix.sv
// N-master x M-slave commutation matrix: per-slave session ports plus master-side return muxes.
// An aborting slave overrides any normal return path to the same master.
module xbar_commutation_matrix #(
  parameter int N_MASTERS      = 4,
  parameter int N_SLAVES       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_SLAVES*N_MASTERS-1:0]    granted_matrix,
  input  logic [N_MASTERS-1:0]             m_req,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS-1:0]             m_cmd,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  output logic [N_MASTERS-1:0]             m_ack,
  output logic [N_MASTERS-1:0]             m_resp,
  output logic [N_MASTERS*DATA_WIDTH-1:0]  m_rdata,
  output logic [N_MASTERS-1:0]             m_err,
  output logic [N_SLAVES-1:0]              s_req,
  output logic [N_SLAVES*ADDR_WIDTH-1:0]   s_addr,
  output logic [N_SLAVES-1:0]              s_cmd,
  output logic [N_SLAVES*DATA_WIDTH-1:0]   s_wdata,
  input  logic [N_SLAVES-1:0]              s_ack,
  input  logic [N_SLAVES-1:0]              s_resp,
  input  logic [N_SLAVES*DATA_WIDTH-1:0]   s_rdata,
  output logic [N_SLAVES-1:0]              session_is_finished,
  output logic [N_SLAVES-1:0]              session_timeout,
  output logic [N_SLAVES-1:0]              slave_busy
);

  import xbar_pkg::*;

  localparam int IDX_WIDTH = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  m2s_t                 m_bus       [N_MASTERS];
  m2s_t                 s_bus       [N_SLAVES];
  s2m_t                 m_rsp       [N_MASTERS];
  logic [IDX_WIDTH-1:0] owner       [N_SLAVES];
  slave_state_t         slave_state [N_SLAVES];
  logic [N_SLAVES-1:0]  owner_live;

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign m_bus[gi] = '{req:   m_req[gi],
                           addr:  m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH],
                           cmd:   m_cmd[gi],
                           wdata: m_wdata[gi*DATA_WIDTH +: DATA_WIDTH]};
      assign m_ack[gi]                           = m_rsp[gi].ack;
      assign m_resp[gi]                          = m_rsp[gi].resp;
      assign m_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_rsp[gi].rdata;
      assign m_err[gi]                           = m_rsp[gi].err;
    end

    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
      xbar_slave_port #(
        .N_MASTERS      (N_MASTERS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH),
        .IDX_WIDTH      (IDX_WIDTH)
      ) u_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant_row  (granted_matrix[gi*N_MASTERS +: N_MASTERS]),
        .m_bus      (m_bus),
        .s_ack      (s_ack[gi]),
        .s_resp     (s_resp[gi]),
        .s_bus      (s_bus[gi]),
        .owner      (owner[gi]),
        .state      (slave_state[gi]),
        .owner_live (owner_live[gi]),
        .finished   (session_is_finished[gi]),
        .timeout    (session_timeout[gi]),
        .busy       (slave_busy[gi])
      );
      assign s_req[gi]                           = s_bus[gi].req;
      assign s_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = s_bus[gi].addr;
      assign s_cmd[gi]                           = s_bus[gi].cmd;
      assign s_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = s_bus[gi].wdata;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      m_rsp[i] = '0;
      // Descending scan so the lowest-index owning slave wins.
      for (int s = N_SLAVES - 1; s >= 0; s--) begin
        if (owner_live[s] && (owner[s] == IDX_WIDTH'(i))) begin
          m_rsp[i].ack   = s_ack[s];
          m_rsp[i].resp  = s_resp[s];
          m_rsp[i].rdata = s_rdata[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      for (int s = 0; s < N_SLAVES; s++) begin
        if ((slave_state[s] == ST_ABORT) && (owner[s] == IDX_WIDTH'(i))) begin
          m_rsp[i]      = '0;
          m_rsp[i].resp = 1'b1;
          m_rsp[i].err  = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_commutation_matrix.sv
// Randomized scoreboard bench for the commutation matrix: drivers push expected master responses,
// an independent monitor pops them whenever a master sees m_resp.
module tb_xbar_commutation_matrix;

  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NS*NM-1:0] granted_matrix;
  logic [NM-1:0]    m_req, m_cmd, m_ack, m_resp, m_err;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata, m_rdata;
  logic [NS-1:0]    s_req, s_cmd, s_ack, s_resp;
  logic [NS*AW-1:0] s_addr;
  logic [NS*DW-1:0] s_wdata, s_rdata;
  logic [NS-1:0]    session_is_finished, session_timeout, slave_busy;

  logic [NM-1:0] row_a   [NS];
  logic          ack_a   [NS];
  logic          resp_a  [NS];
  logic [DW-1:0] rdata_a [NS];
  logic          req_a   [NM];
  logic          cmd_a   [NM];
  logic [AW-1:0] addr_a  [NM];
  logic [DW-1:0] wdata_a [NM];
  bit            m_free  [NM];

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t exp_q [NM][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_s
      assign granted_matrix[gi*NM +: NM] = row_a[gi];
      assign s_ack[gi]                   = ack_a[gi];
      assign s_resp[gi]                  = resp_a[gi];
      assign s_rdata[gi*DW +: DW]        = rdata_a[gi];
    end
    for (gi = 0; gi < NM; gi++) begin : g_m
      assign m_req[gi]            = req_a[gi];
      assign m_cmd[gi]            = cmd_a[gi];
      assign m_addr[gi*AW +: AW]  = addr_a[gi];
      assign m_wdata[gi*DW +: DW] = wdata_a[gi];
    end
  endgenerate

  xbar_commutation_matrix #(
    .N_MASTERS      (NM),
    .N_SLAVES       (NS),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .granted_matrix      (granted_matrix),
    .m_req               (m_req),
    .m_addr              (m_addr),
    .m_cmd               (m_cmd),
    .m_wdata             (m_wdata),
    .m_ack               (m_ack),
    .m_resp              (m_resp),
    .m_rdata             (m_rdata),
    .m_err               (m_err),
    .s_req               (s_req),
    .s_addr              (s_addr),
    .s_cmd               (s_cmd),
    .s_wdata             (s_wdata),
    .s_ack               (s_ack),
    .s_resp              (s_resp),
    .s_rdata             (s_rdata),
    .session_is_finished (session_is_finished),
    .session_timeout     (session_timeout),
    .slave_busy          (slave_busy)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Session model: mode 0 = ack at cycle a then resp at cycle r, 1 = ack+resp at cycle a,
  // 2 = slave silent until watchdog abort. Cycle 0 is the grant cycle; called at a negedge.
  task automatic run_session(input int s, input int m, input logic [NM-1:0] row, input int mode,
                             input int a, input int r, input logic [DW-1:0] rd,
                             input logic [NM-1:0] junk);
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          cmd;
    int            term;
    exp_t          e;
    addr = $urandom;
    wd   = $urandom;
    cmd  = 1'($urandom_range(0, 1));
    term = (mode == 0) ? r : (mode == 1) ? a : TO + 1;
    req_a[m] = 1'b1; addr_a[m] = addr; cmd_a[m] = cmd; wdata_a[m] = wd; row_a[s] = row;
    #1;
    chk("s_req_start",   64'(s_req[s]), 64'(1));
    chk("s_addr_start",  64'(s_addr[s*AW +: AW]), 64'(addr));
    chk("s_cmd_start",   64'(s_cmd[s]), 64'(cmd));
    chk("s_wdata_start", 64'(s_wdata[s*DW +: DW]), 64'(wd));
    chk("busy_start",    64'(slave_busy[s]), 64'(0));
    for (int k = 1; k <= term + 1; k++) begin
      @(negedge clk);
      row_a[s]   = (mode == 2 || k >= term) ? '0 : junk;
      ack_a[s]   = (mode != 2) && (k == a);
      resp_a[s]  = (mode != 2) && (k == term);
      rdata_a[s] = ((mode != 2) && (k == term)) ? rd : DW'($urandom);
      if (k == term) begin
        e.rdata = (mode == 2) ? '0 : rd;
        e.err   = (mode == 2);
        exp_q[m].push_back(e);
      end
      #1;
      if (k <= term) begin
        chk("busy_mid",       64'(slave_busy[s]), 64'(1));
        chk("finished_early", 64'(session_is_finished[s]), 64'(0));
        chk("m_ack",          64'(m_ack[m]), 64'((mode != 2) && (k == a)));
        if (mode == 2 && k == term) begin
          chk("s_req_abort", 64'(s_req[s]), 64'(0));
        end else begin
          chk("s_req_hold",  64'(s_req[s]), 64'(1));
          chk("s_addr_hold", 64'(s_addr[s*AW +: AW]), 64'(addr));
        end
      end else begin
        chk("finished_pulse", 64'(session_is_finished[s]), 64'(1));
        chk("timeout_pulse",  64'(session_timeout[s]), 64'(mode == 2));
        chk("busy_end",       64'(slave_busy[s]), 64'(0));
        chk("s_req_idle",     64'(s_req[s]), 64'(0));
      end
    end
    ack_a[s] = 1'b0; resp_a[s] = 1'b0; req_a[m] = 1'b0;
    m_free[m] = 1'b1;
    $display("session slave=%0d master=%0d mode=%0d ack_cycle=%0d end_cycle=%0d", s, m, mode, a, term);
  endtask

  task automatic slave_driver(input int s, input int n);
    int m, mode, a, r, hi, c;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      m = -1;
      while (m < 0) begin
        c = int'($urandom_range(0, NM - 1));
        if (m_free[c]) begin
          m = c;
          m_free[c] = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
      hi   = int'($urandom_range(0, 15)) & ~((2 << m) - 1);
      mode = int'($urandom_range(0, 9));
      mode = (mode < 6) ? 0 : (mode < 8) ? 1 : 2;
      a    = int'($urandom_range(1, TO));
      r    = a + int'($urandom_range(1, TO));
      run_session(s, m, NM'(hi | (1 << m)), mode, a, r, DW'($urandom), NM'($urandom));
    end
  endtask

  // Monitor: every response a master sees must match the oldest expectation for that master.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NM; i++) begin
        if (m_resp[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: master %0d got m_resp=1, required none (t=%0t)", i, $time);
          end else begin
            e = exp_q[i].pop_front();
            chk("m_rdata", 64'(m_rdata[i*DW +: DW]), 64'(e.rdata));
            chk("m_err",   64'(m_err[i]), 64'(e.err));
          end
        end else if (m_err[i]) begin
          chk("m_err_idle", 64'(m_err[i]), 64'(0));
        end
      end
    end
  end

  initial begin
    #400000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      row_a[i] = '0; ack_a[i] = 1'b0; resp_a[i] = 1'b0; rdata_a[i] = '0;
    end
    for (int i = 0; i < NM; i++) begin
      req_a[i] = 1'b0; cmd_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0; m_free[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_req",    64'(s_req), 64'(0));
    chk("rst_s_addr",   64'(s_addr[AW-1:0]), 64'(0));
    chk("rst_m_ack",    64'(m_ack), 64'(0));
    chk("rst_m_resp",   64'(m_resp), 64'(0));
    chk("rst_m_err",    64'(m_err), 64'(0));
    chk("rst_m_rdata",  64'(m_rdata[DW-1:0]), 64'(0));
    chk("rst_finished", 64'(session_is_finished), 64'(0));
    chk("rst_timeout",  64'(session_timeout), 64'(0));
    chk("rst_busy",     64'(slave_busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: basic read, grant switched mid-session, abort, ack+resp together, boundary delays.
    @(negedge clk); run_session(0, 1, 4'b0010, 0, 2, 4, 32'hA5, 4'b0000);
    @(negedge clk); run_session(3, 2, 4'b0100, 0, 1, 5, 32'h1234_5678, 4'b0001);
    @(negedge clk); run_session(0, 0, 4'b0001, 2, 0, 0, 32'h0, 4'b0000);
    @(negedge clk); run_session(1, 3, 4'b1000, 1, 1, 0, 32'hDEAD_BEEF, 4'b0010);
    @(negedge clk); run_session(2, 1, 4'b1010, 0, TO, 2 * TO, 32'h0BAD_F00D, 4'b1111);
    @(negedge clk);
    fork
      run_session(1, 1, 4'b0110, 0, 2, 3, 32'h1111_0001, 4'b0000);
      run_session(0, 0, 4'b0001, 0, 1, 4, 32'h0000_0AA0, 4'b0000);
      run_session(2, 3, 4'b1000, 1, 3, 0, 32'h3333_0003, 4'b0000);
    join

    // Reset while waiting for a response: session vanishes without a finished pulse.
    @(negedge clk);
    req_a[2] = 1'b1; addr_a[2] = 32'h2000; row_a[2] = 4'b0100;
    @(negedge clk); row_a[2] = '0; ack_a[2] = 1'b1;
    @(negedge clk); ack_a[2] = 1'b0;
    #1 chk("busy_wait_resp", 64'(slave_busy[2]), 64'(1));
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("mid_rst_busy",     64'(slave_busy[2]), 64'(0));
    chk("mid_rst_s_req",    64'(s_req[2]), 64'(0));
    chk("mid_rst_s_addr",   64'(s_addr[2*AW +: AW]), 64'(0));
    chk("mid_rst_finished", 64'(session_is_finished[2]), 64'(0));
    chk("mid_rst_m_resp",   64'(m_resp), 64'(0));
    @(negedge clk);
    #1;
    chk("post_rst_finished", 64'(session_is_finished[2]), 64'(0));
    chk("post_rst_timeout",  64'(session_timeout[2]), 64'(0));
    req_a[2] = 1'b0;

    fork
      slave_driver(0, 25);
      slave_driver(1, 25);
      slave_driver(2, 25);
      slave_driver(3, 25);
    join

    @(negedge clk);
    #2;
    for (int i = 0; i < NM; i++) begin
      chk("pending_resp", 64'(exp_q[i].size()), 64'(0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
